// File: rtl/cnn_accel_pkg.sv
// Shared constants for the CNN accelerator register block: word indices,
// LAYER_CONFIG bit positions, field widths and AHB transfer encodings.
package cnn_accel_pkg;

    localparam int IDX_FRAME_SIZE       = 0;
    localparam int IDX_WIDTH_HEIGHT     = 1;
    localparam int IDX_DELAY_PARAMS     = 2;
    localparam int IDX_BASE_ADDRESS     = 3;
    localparam int IDX_LAYER_CONFIG     = 4;
    localparam int IDX_LAYER_START      = 5;
    localparam int IDX_LAYER_DONE       = 6;
    localparam int IDX_INPUT_IMAGE_BASE = 7;
    localparam int IDX_INPUT_IMAGE_LOAD = 8;

    localparam int LC_IS_FIRST    = 0;
    localparam int LC_IS_LAST     = 1;
    localparam int LC_IS_CONV3X3  = 2;
    localparam int LC_IS_LAST_DUP = 3;
    localparam int LC_INDEX_LSB   = 4;
    localparam int LC_BIAS_LSB    = 8;
    localparam int LC_ACT_LSB     = 13;

    localparam int W_SIZE         = 12;
    localparam int W_FRAME_SIZE   = 25;
    localparam int W_DELAY        = 12;
    localparam int W_BASE_WEIGHT  = 20;
    localparam int W_BASE_PARAM   = 12;
    localparam int W_LAYER_CONFIG = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        SD_IDLE = 1'b0,
        SD_BUSY = 1'b1
    } sd_state_e;

endpackage

// File: rtl/start_done_ctrl.sv
// IDLE/BUSY handshake: a start while idle emits a one-cycle pulse and clears
// the sticky done bit; the engine's done pulse returns to idle and sets it.
module start_done_ctrl
    import cnn_accel_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_done,
    output logic o_start_pulse,
    output logic o_done
);

    sd_state_e r_state;
    logic      r_pulse;
    logic      r_done;

    // Start is only accepted in IDLE, so a done arriving with a start while
    // BUSY naturally wins; a done in IDLE is dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SD_IDLE;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                SD_IDLE: if (i_start) begin
                    r_state <= SD_BUSY;
                    r_pulse <= 1'b1;
                    r_done  <= 1'b0;
                end
                SD_BUSY: if (i_done) begin
                    r_state <= SD_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= SD_IDLE;
            endcase
        end
    end

    assign o_start_pulse = r_pulse;
    assign o_done        = r_done;

endmodule

// File: rtl/cnn_accel_ahb_regs.sv
// Zero-wait AHB-Lite register file for the CNN accelerator: geometry, base
// addresses, layer config, and start/done handshakes for the core and DMA.
module cnn_accel_ahb_regs
    import cnn_accel_pkg::*;
#(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32,
    parameter int N_REGS = 21
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HSEL,
    input  logic [W_ADDR-1:0]         HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [2:0]                HSIZE,
    input  logic [W_DATA-1:0]         HWDATA,
    input  logic                      HREADY,
    output logic                      HREADYOUT,
    output logic                      HRESP,
    output logic [W_DATA-1:0]         HRDATA,
    output logic [W_FRAME_SIZE-1:0]   o_frame_size,
    output logic [W_SIZE-1:0]         o_width,
    output logic [W_SIZE-1:0]         o_height,
    output logic [W_DELAY-1:0]        o_start_up_delay,
    output logic [W_DELAY-1:0]        o_hsync_delay,
    output logic [W_BASE_WEIGHT-1:0]  o_base_weight,
    output logic [W_BASE_PARAM-1:0]   o_base_param,
    output logic [W_LAYER_CONFIG-1:0] o_layer_config,
    output logic                      o_layer_start,
    input  logic                      i_layer_done,
    output logic [31:0]               o_image_base,
    output logic                      o_image_load,
    input  logic                      i_image_load_done
);

    localparam int W_REGS = $clog2(N_REGS);

    logic                      r_sel_q;
    logic                      r_write_q;
    logic [W_REGS-1:0]         r_idx_q;
    logic [W_FRAME_SIZE-1:0]   r_frame_size;
    logic [W_SIZE-1:0]         r_width;
    logic [W_SIZE-1:0]         r_height;
    logic [W_DELAY-1:0]        r_start_up_delay;
    logic [W_DELAY-1:0]        r_hsync_delay;
    logic [W_BASE_WEIGHT-1:0]  r_base_weight;
    logic [W_BASE_PARAM-1:0]   r_base_param;
    logic [W_LAYER_CONFIG-1:0] r_layer_config;
    logic [31:0]               r_image_base;

    logic              w_wr;
    logic              w_layer_start;
    logic              w_image_load;
    logic              w_layer_done;
    logic              w_load_done;
    logic [W_DATA-1:0] w_rdata;
    logic              w_unused;

    assign w_unused = ^{HSIZE, HTRANS[0], HADDR[W_ADDR-1:W_REGS+2], HADDR[1:0]};

    // Address phase; IDLE/BUSY transfers leave r_sel_q low so nothing commits.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sel_q   <= 1'b0;
            r_write_q <= 1'b0;
            r_idx_q   <= '0;
        end else if (HREADY) begin
            r_sel_q   <= HSEL & HTRANS[1];
            r_write_q <= HWRITE;
            r_idx_q   <= HADDR[W_REGS+1:2];
        end
    end

    assign w_wr          = r_sel_q & r_write_q & HREADY;
    assign w_layer_start = w_wr & (r_idx_q == W_REGS'(IDX_LAYER_START))      & HWDATA[0];
    assign w_image_load  = w_wr & (r_idx_q == W_REGS'(IDX_INPUT_IMAGE_LOAD)) & HWDATA[0];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_frame_size     <= '0;
            r_width          <= '0;
            r_height         <= '0;
            r_start_up_delay <= '0;
            r_hsync_delay    <= '0;
            r_base_weight    <= '0;
            r_base_param     <= '0;
            r_layer_config   <= '0;
            r_image_base     <= '0;
        end else if (w_wr) begin
            case (r_idx_q)
                W_REGS'(IDX_FRAME_SIZE): r_frame_size <= HWDATA[W_FRAME_SIZE-1:0];
                W_REGS'(IDX_WIDTH_HEIGHT): begin
                    r_width  <= HWDATA[0 +: W_SIZE];
                    r_height <= HWDATA[16 +: W_SIZE];
                end
                W_REGS'(IDX_DELAY_PARAMS): begin
                    r_start_up_delay <= HWDATA[0 +: W_DELAY];
                    r_hsync_delay    <= HWDATA[12 +: W_DELAY];
                end
                W_REGS'(IDX_BASE_ADDRESS): begin
                    r_base_weight <= HWDATA[0 +: W_BASE_WEIGHT];
                    r_base_param  <= HWDATA[20 +: W_BASE_PARAM];
                end
                W_REGS'(IDX_LAYER_CONFIG):     r_layer_config <= HWDATA[W_LAYER_CONFIG-1:0];
                W_REGS'(IDX_INPUT_IMAGE_BASE): r_image_base   <= HWDATA[31:0];
                default: ;
            endcase
        end
    end

    start_done_ctrl u_layer_ctrl (
        .i_clk         (HCLK),
        .i_rst         (HRESET),
        .i_start       (w_layer_start),
        .i_done        (i_layer_done),
        .o_start_pulse (o_layer_start),
        .o_done        (w_layer_done)
    );

    start_done_ctrl u_dma_ctrl (
        .i_clk         (HCLK),
        .i_rst         (HRESET),
        .i_start       (w_image_load),
        .i_done        (i_image_load_done),
        .o_start_pulse (o_image_load),
        .o_done        (w_load_done)
    );

    always_comb begin
        w_rdata = '0;
        if (r_sel_q && !r_write_q) begin
            case (r_idx_q)
                W_REGS'(IDX_FRAME_SIZE): w_rdata[W_FRAME_SIZE-1:0] = r_frame_size;
                W_REGS'(IDX_WIDTH_HEIGHT): begin
                    w_rdata[0 +: W_SIZE]  = r_width;
                    w_rdata[16 +: W_SIZE] = r_height;
                end
                W_REGS'(IDX_DELAY_PARAMS): begin
                    w_rdata[0 +: W_DELAY]  = r_start_up_delay;
                    w_rdata[12 +: W_DELAY] = r_hsync_delay;
                end
                W_REGS'(IDX_BASE_ADDRESS): begin
                    w_rdata[0 +: W_BASE_WEIGHT] = r_base_weight;
                    w_rdata[20 +: W_BASE_PARAM] = r_base_param;
                end
                W_REGS'(IDX_LAYER_CONFIG):     w_rdata[W_LAYER_CONFIG-1:0] = r_layer_config;
                W_REGS'(IDX_LAYER_DONE):       w_rdata[0] = w_layer_done;
                W_REGS'(IDX_INPUT_IMAGE_BASE): w_rdata[31:0] = r_image_base;
                W_REGS'(IDX_INPUT_IMAGE_LOAD): w_rdata[0] = w_load_done;
                default: ;
            endcase
        end
    end

    assign HRDATA           = w_rdata;
    assign HREADYOUT        = 1'b1;
    assign HRESP            = 1'b0;
    assign o_frame_size     = r_frame_size;
    assign o_width          = r_width;
    assign o_height         = r_height;
    assign o_start_up_delay = r_start_up_delay;
    assign o_hsync_delay    = r_hsync_delay;
    assign o_base_weight    = r_base_weight;
    assign o_base_param     = r_base_param;
    assign o_layer_config   = r_layer_config;
    assign o_image_base     = r_image_base;

endmodule

// File: tb/tb_cnn_accel_ahb_regs.sv
// Self-checking bench: directed bring-up sequence then random AHB traffic,
// compared against a word-level register/handshake model.
module tb_cnn_accel_ahb_regs;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b010;
    logic [31:0] HWDATA = '0;
    logic        HREADY = 1'b1;
    logic        HREADYOUT, HRESP;
    logic [31:0] HRDATA;
    logic [24:0] o_frame_size;
    logic [11:0] o_width, o_height, o_start_up_delay, o_hsync_delay, o_base_param;
    logic [19:0] o_base_weight;
    logic [15:0] o_layer_config;
    logic        o_layer_start, o_image_load;
    logic        i_layer_done = 1'b0;
    logic        i_image_load_done = 1'b0;
    logic [31:0] o_image_base;

    cnn_accel_ahb_regs dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .o_frame_size(o_frame_size), .o_width(o_width), .o_height(o_height),
        .o_start_up_delay(o_start_up_delay), .o_hsync_delay(o_hsync_delay),
        .o_base_weight(o_base_weight), .o_base_param(o_base_param),
        .o_layer_config(o_layer_config), .o_layer_start(o_layer_start),
        .i_layer_done(i_layer_done), .o_image_base(o_image_base),
        .o_image_load(o_image_load), .i_image_load_done(i_image_load_done)
    );

    always #5 HCLK = ~HCLK;

    int n_tot = 0, n_bad = 0;
    int n_ls = 0, n_il = 0, exp_ls = 0, exp_il = 0;
    logic [31:0] m_reg [32];
    bit m_lbusy, m_ldone, m_ibusy, m_idone;
    logic [31:0] rd;

    always @(negedge HCLK) begin
        if (o_layer_start) n_ls++;
        if (o_image_load)  n_il++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_lbusy = 0; m_ldone = 0; m_ibusy = 0; m_idone = 0;
    endfunction

    function automatic void sd_step(input bit start, input bit done,
                                    inout bit busy, inout bit dn, inout int cnt);
        if (busy) begin
            if (done) begin busy = 0; dn = 1; end
        end else if (start) begin
            busy = 1; dn = 0; cnt++;
        end
    endfunction

    function automatic void m_write(input int idx, input logic [31:0] d, input bit ld, input bit il);
        case (idx)
            0: m_reg[0] = d & 32'h01FF_FFFF;
            1: m_reg[1] = d & 32'h0FFF_0FFF;
            2: m_reg[2] = d & 32'h00FF_FFFF;
            3: m_reg[3] = d;
            4: m_reg[4] = d & 32'h0000_FFFF;
            7: m_reg[7] = d;
            default: ;
        endcase
        sd_step(idx == 5 && d[0], ld, m_lbusy, m_ldone, exp_ls);
        sd_step(idx == 8 && d[0], il, m_ibusy, m_idone, exp_il);
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0, 1, 2, 3, 4, 7: return m_reg[idx];
            6: return 32'(m_ldone);
            8: return 32'(m_idone);
            default: return 32'h0;
        endcase
    endfunction

    task automatic ahb_write(input int idx, input logic [31:0] d, input bit ld = 0, input bit il = 0);
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HSIZE = 3'($urandom_range(0, 2));
        HADDR = 32'h4000_0000 | (32'(idx) << 2);
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        i_layer_done = ld; i_image_load_done = il;
        m_write(idx, d, ld, il);
        @(negedge HCLK);
        i_layer_done = 0; i_image_load_done = 0;
    endtask

    task automatic ahb_read(input int idx, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b11; HWRITE = 0;
        HADDR = 32'h4000_0000 | (32'(idx) << 2);
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00;
        d = HRDATA;
    endtask

    task automatic read_chk(input string tag, input int idx);
        logic [31:0] v;
        ahb_read(idx, v);
        chk(tag, v, m_read(idx));
    endtask

    task automatic pulse_done(input bit ld, input bit il);
        @(negedge HCLK);
        i_layer_done = ld; i_image_load_done = il;
        sd_step(0, ld, m_lbusy, m_ldone, exp_ls);
        sd_step(0, il, m_ibusy, m_idone, exp_il);
        @(negedge HCLK);
        i_layer_done = 0; i_image_load_done = 0;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".frame"},  32'(o_frame_size),     m_reg[0] & 32'h01FF_FFFF);
        chk({tag, ".width"},  32'(o_width),          m_reg[1] & 32'h0000_0FFF);
        chk({tag, ".height"}, 32'(o_height),         (m_reg[1] >> 16) & 32'h0FFF);
        chk({tag, ".sud"},    32'(o_start_up_delay), m_reg[2] & 32'h0000_0FFF);
        chk({tag, ".hsd"},    32'(o_hsync_delay),    (m_reg[2] >> 12) & 32'h0FFF);
        chk({tag, ".bw"},     32'(o_base_weight),    m_reg[3] & 32'h000F_FFFF);
        chk({tag, ".bp"},     32'(o_base_param),     m_reg[3] >> 20);
        chk({tag, ".lcfg"},   32'(o_layer_config),   m_reg[4] & 32'h0000_FFFF);
        chk({tag, ".ibase"},  o_image_base,          m_reg[7]);
    endtask

    task automatic chk_counts(input string tag);
        @(negedge HCLK);
        chk({tag, ".ls_cnt"}, 32'(n_ls), 32'(exp_ls));
        chk({tag, ".il_cnt"}, 32'(n_il), 32'(exp_il));
    endtask

    initial begin
        m_reset();
        repeat (3) @(negedge HCLK);
        HRESET = 0;
        @(negedge HCLK);
        chk_outs("rst");
        chk("rst.hrdata", HRDATA, 32'h0);
        chk("rst.hreadyout", 32'(HREADYOUT), 32'h1);
        chk("rst.hresp", 32'(HRESP), 32'h0);
        chk("rst.pulses", 32'({o_layer_start, o_image_load}), 32'h0);

        ahb_write(0, 32'h0000_4000);
        read_chk("frame.rd", 0);
        chk("frame.out", 32'(o_frame_size), 32'h4000);

        ahb_write(1, 32'h0080_0080);
        ahb_write(2, 32'h000A_00C8);
        chk("geo.width", 32'(o_width), 32'd128);
        chk("geo.height", 32'(o_height), 32'd128);
        chk("geo.hsync", 32'(o_hsync_delay), 32'd160);
        chk("geo.sud", 32'(o_start_up_delay), 32'd200);

        ahb_write(4, 32'hFFFF_E916);
        chk("lcfg.act", 32'(o_layer_config[15:13]), 32'd7);
        chk("lcfg.bias", 32'(o_layer_config[12:8]), 32'd9);
        chk("lcfg.index", 32'(o_layer_config[7:4]), 32'd1);
        chk("lcfg.conv", 32'(o_layer_config[2]), 32'd1);
        chk("lcfg.last", 32'(o_layer_config[1]), 32'd1);
        chk("lcfg.first", 32'(o_layer_config[0]), 32'd0);
        read_chk("lcfg.rd", 4);

        // IDLE transfer with HSEL/HWRITE set must not commit
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b00; HWRITE = 1; HADDR = 32'h0;
        @(negedge HCLK);
        HSEL = 0; HWRITE = 0; HWDATA = 32'hDEAD_BEEF;
        @(negedge HCLK);
        chk("idle.frame", 32'(o_frame_size), 32'h4000);

        ahb_write(5, 32'h0);
        chk_counts("start0");
        ahb_write(5, 32'h1);
        chk_counts("start1");
        read_chk("ldone.busy", 6);
        read_chk("lstart.rd", 5);
        pulse_done(1, 0);
        read_chk("ldone.set", 6);
        ahb_write(5, 32'h1);
        read_chk("ldone.clr", 6);
        ahb_write(5, 32'h1);
        ahb_write(5, 32'h1, 1, 0);
        chk_counts("busy_start");
        read_chk("ldone.sim", 6);
        chk("ldone.sim1", m_read(6), 32'h1);
        pulse_done(1, 0);
        read_chk("ldone.idle_done", 6);

        ahb_write(7, 32'h0);
        ahb_write(8, 32'h1);
        chk_counts("dma");
        read_chk("idone.busy", 8);
        pulse_done(0, 1);
        read_chk("idone.set", 8);
        ahb_write(12, 32'hFFFF_FFFF);
        read_chk("idx12", 12);
        chk_outs("dir");

        // reset during the data phase of a write: nothing commits
        ahb_write(3, 32'hABCD_E123);
        @(negedge HCLK);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0;
        @(negedge HCLK);
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = 32'h0155_5555; HRESET = 1;
        @(negedge HCLK);
        HRESET = 0;
        m_reset();
        @(negedge HCLK);
        chk_outs("midrst");
        read_chk("midrst.rd", 0);

        for (int it = 0; it < 120; it++) begin
            int op, idx;
            logic [31:0] d;
            op = $urandom_range(0, 3);
            idx = (op == 3) ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(5, 8) : $urandom_range(0, 31));
            d = $urandom;
            if (op <= 1) begin
                ahb_write(idx, d, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
                chk_outs("rnd");
            end else if (op == 2) begin
                read_chk("rnd.rd", idx);
            end else begin
                pulse_done($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            end
        end
        chk_counts("rnd");
        for (int i = 0; i < 9; i++) read_chk("final.rd", i);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
